// File: rtl/axpy_chunk_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the chunked axpy sequencer.
// Chunk count, remainder and last-chunk lane mask are computed here so sibling sequencers agree.
package axpy_chunk_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

  localparam int MAX_NI = 256;

  function automatic int calc_nchunk(int noe, int ni);
    return (noe + ni - 1) / ni;
  endfunction

  function automatic int calc_rem(int noe, int ni);
    return noe % ni;
  endfunction

  // Element e of a chunk sits in lane ni-1-e, so a partial chunk fills from the top.
  function automatic logic [MAX_NI-1:0] last_mask(int rem, int ni);
    logic [MAX_NI-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_NI; b++)
      if (b < ni && (rem == 0 || b >= ni - rem)) m[b] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axpy_chunk_sequencer_if.sv
// Controller, operand-memory and datapath signals of the axpy chunk sequencer.
interface axpy_chunk_sequencer_if #(
  parameter int EW = 32,
  parameter int NI = 8,
  parameter int AW = 8
);
  logic          start;
  logic          op_in;
  logic [EW-1:0] constant_in;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          dp_op;
  logic [EW-1:0] dp_constant;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NI-1:0] wr_mask;

  modport slave (
    input  start, op_in, constant_in,
    output busy, done, rd_en, rd_addr, dp_op, dp_constant, wr_en, wr_addr, wr_mask
  );

  modport master (
    output start, op_in, constant_in,
    input  busy, done, rd_en, rd_addr, dp_op, dp_constant, wr_en, wr_addr, wr_mask
  );
endinterface

// File: rtl/axpy_chunk_sequencer_latency_tag_pipe.sv
// Depth-DEPTH shift register of {valid, addr, last} tags matching datapath latency.
// pending flags any tag not yet in the output stage, letting a sequencer finish as the last write leaves.
module latency_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic          in_last,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          pending
);

  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][AW-1:0] addr_pipe;
  logic [DEPTH-1:0]         last_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      last_pipe <= '0;
    end else begin
      // Payload is zeroed on empty slots so idle outputs read as 0.
      vld_pipe[0]  <= in_valid;
      addr_pipe[0] <= in_valid ? in_addr : '0;
      last_pipe[0] <= in_valid & in_last;
      for (int s = 1; s < DEPTH; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int s = 0; s < DEPTH-1; s++) pending = pending | vld_pipe[s];
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_addr  = addr_pipe[DEPTH-1];
  assign out_last  = last_pipe[DEPTH-1];

endmodule

// File: rtl/axpy_chunk_sequencer.sv
// Issues one NOE-element axpy run chunk by chunk, holds op/constant for the run,
// and emits latency-aligned write-back strobes followed by a one-cycle done.
module axpy_chunk_sequencer
  import axpy_chunk_sequencer_pkg::*;
#(
  parameter int NOE    = 16,
  parameter int NI     = 8,
  parameter int EW     = 32,
  parameter int LAT    = 5,
  parameter int RD_LAT = 1,
  parameter int AW     = 8
) (
  input logic                  clk,
  input logic                  reset,
  axpy_chunk_sequencer_if.slave bus
);

  localparam int NCHUNK = calc_nchunk(NOE, NI);
  localparam int REM    = calc_rem(NOE, NI);
  localparam int TOT    = RD_LAT + LAT;
  localparam logic [AW-1:0]     LAST_IDX    = AW'(NCHUNK - 1);
  localparam logic [MAX_NI-1:0] LAST_MASK_W = last_mask(REM, NI);

  seq_state_t    state;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          dp_op_q;
  logic [EW-1:0] dp_const_q;
  logic          busy_q;
  logic          done_q;

  logic          tag_valid;
  logic [AW-1:0] tag_addr;
  logic          tag_last;
  logic          tag_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      dp_op_q    <= 1'b0;
      dp_const_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state      <= ISSUE;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= '0;
          dp_op_q    <= bus.op_in;
          dp_const_q <= bus.constant_in;
          busy_q     <= 1'b1;
        end
        ISSUE: begin
          if (rd_addr_q == LAST_IDX) begin
            state   <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        // Leave as the final tag reaches the output stage so done lands right after the last write.
        DRAIN: if (!tag_pending) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  latency_tag_pipe #(.DEPTH(TOT), .AW(AW)) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_en_q),
    .in_addr  (rd_addr_q),
    .in_last  (rd_addr_q == LAST_IDX),
    .out_valid(tag_valid),
    .out_addr (tag_addr),
    .out_last (tag_last),
    .pending  (tag_pending)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.dp_op       = dp_op_q;
  assign bus.dp_constant = dp_const_q;
  assign bus.wr_en       = tag_valid;
  assign bus.wr_addr     = tag_addr;
  assign bus.wr_mask     = !tag_valid ? '0 : (tag_last ? LAST_MASK_W[NI-1:0] : '1);

endmodule

// File: tb/tb_axpy_chunk_sequencer.sv
// Bench for axpy_chunk_sequencer: three instances (NOE 16, 20, 8) share stimulus;
// directed scenarios use literal schedules, the random phase uses a run-window reference model.
module tb_axpy_chunk_sequencer;
  localparam int NI = 8, EW = 32, AW = 8, LAT = 5, RD_LAT = 1, TOT = RD_LAT + LAT, ND = 3;

  function automatic int noe_of(int i);
    case (i)
      0: return 16;
      1: return 20;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset, start, op_in;
  logic [EW-1:0] constant_in;
  always #5 clk = ~clk;

  logic          o_busy[ND], o_done[ND], o_rd_en[ND], o_dp_op[ND], o_wr_en[ND];
  logic [AW-1:0] o_rd_addr[ND], o_wr_addr[ND];
  logic [EW-1:0] o_dp_const[ND];
  logic [NI-1:0] o_wr_mask[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    axpy_chunk_sequencer_if #(.EW(EW), .NI(NI), .AW(AW)) bus ();
    assign bus.start       = start;
    assign bus.op_in       = op_in;
    assign bus.constant_in = constant_in;
    axpy_chunk_sequencer #(.NOE(noe_of(g)), .NI(NI), .EW(EW), .LAT(LAT), .RD_LAT(RD_LAT), .AW(AW))
      dut (.clk(clk), .reset(reset), .bus(bus));
    assign o_busy[g]     = bus.busy;
    assign o_done[g]     = bus.done;
    assign o_rd_en[g]    = bus.rd_en;
    assign o_rd_addr[g]  = bus.rd_addr;
    assign o_dp_op[g]    = bus.dp_op;
    assign o_dp_const[g] = bus.dp_constant;
    assign o_wr_en[g]    = bus.wr_en;
    assign o_wr_addr[g]  = bus.wr_addr;
    assign o_wr_mask[g]  = bus.wr_mask;
  end

  int total = 0, bad = 0;
  int cyc = 0;

  // Reference model: a run is a window of cycles relative to the accepted start.
  bit            run_on[ND];
  int            run_s[ND];
  logic          m_op[ND];
  logic [EW-1:0] m_cst[ND];

  function automatic int nch(int i);
    return (noe_of(i) + NI - 1) / NI;
  endfunction

  function automatic bit m_idle(int i);
    return !run_on[i] || (cyc - run_s[i] >= nch(i) + TOT + 2);
  endfunction

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NI-1:0] mask;
    logic          busy;
    logic          done;
  } exp_t;

  function automatic exp_t m_exp(int i);
    exp_t e;
    int k, n, c;
    e = '{default: '0};
    k = cyc - run_s[i];
    n = nch(i);
    if (run_on[i]) begin
      e.rd_en   = (k >= 1 && k <= n);
      e.rd_addr = AW'(k - 1);
      e.wr_en   = (k >= TOT + 1 && k <= TOT + n);
      c = k - TOT - 1;
      e.wr_addr = AW'(c);
      for (int el = 0; el < NI; el++)
        if (c * NI + el < noe_of(i)) e.mask[NI-1-el] = 1'b1;
      e.busy = (k >= 1 && k <= n + TOT);
      e.done = (k == n + TOT + 1);
    end
    return e;
  endfunction

  // Inputs of the current cycle are applied to the model, then time moves to the next sample point.
  task automatic adv();
    for (int i = 0; i < ND; i++) begin
      if (reset) begin
        run_on[i] = 0; m_op[i] = 1'b0; m_cst[i] = '0;
      end else if (start && m_idle(i)) begin
        run_on[i] = 1; run_s[i] = cyc; m_op[i] = op_in; m_cst[i] = constant_in;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op_in = 1'b1; constant_in = 32'hDEADBEEF;
    repeat (3) adv();
    start = 1'b0;
    for (int i = 0; i < ND; i++) begin
      total++;
      if ({o_busy[i], o_done[i], o_rd_en[i], o_rd_addr[i], o_dp_op[i], o_dp_const[i],
           o_wr_en[i], o_wr_addr[i], o_wr_mask[i]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d busy=%b done=%b rd_en=%b rd_addr=%h dp_op=%b dp_const=%h wr_en=%b wr_addr=%h mask=%h (all expected 0)",
                 i, o_busy[i], o_done[i], o_rd_en[i], o_rd_addr[i], o_dp_op[i], o_dp_const[i],
                 o_wr_en[i], o_wr_addr[i], o_wr_mask[i]);
      end
    end
    reset = 1'b0;
    repeat (2) adv();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (o_busy[i] !== 1'b0 || o_rd_en[i] !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset dut%0d busy=%b rd_en=%b expected 0", i, o_busy[i], o_rd_en[i]);
      end
    end
  endtask

  // Cycle 0 carries start; per-instance chunk counts 2, 3, 1.
  task automatic test_nominal();
    int nread[ND] = '{2, 3, 1};
    for (int t = 0; t <= 12; t++) begin
      for (int i = 0; i < ND; i++) begin
        logic er, ew, ed, eb;
        logic [NI-1:0] em;
        er = (t >= 1 && t <= nread[i]);
        ew = (t >= 7 && t < 7 + nread[i]);
        ed = (t == 7 + nread[i]);
        eb = (t >= 1 && t < 7 + nread[i]);
        em = (i == 1 && t == 9) ? 8'hF0 : 8'hFF;
        total++;
        if (o_rd_en[i] !== er || o_wr_en[i] !== ew || o_done[i] !== ed || o_busy[i] !== eb) begin
          bad++;
          $display("FAIL nominal_strobes dut%0d t=%0d rd_en=%b/%b wr_en=%b/%b done=%b/%b busy=%b/%b (got/exp)",
                   i, t, o_rd_en[i], er, o_wr_en[i], ew, o_done[i], ed, o_busy[i], eb);
        end
        if (er) begin
          total++;
          if (o_rd_addr[i] !== AW'(t - 1)) begin
            bad++; $display("FAIL nominal_rd_addr dut%0d t=%0d got=%0d exp=%0d", i, t, o_rd_addr[i], t - 1);
          end
        end
        if (ew) begin
          total++;
          if (o_wr_addr[i] !== AW'(t - 7) || o_wr_mask[i] !== em) begin
            bad++;
            $display("FAIL nominal_write dut%0d t=%0d addr=%0d exp=%0d mask=%h exp=%h",
                     i, t, o_wr_addr[i], t - 7, o_wr_mask[i], em);
          end
        end
      end
      start = (t == 0); op_in = 1'b0; constant_in = 32'h3F800000;
      if (t == 0) start = 1'b1; else start = 1'b0;
      adv();
    end
  endtask

  task automatic test_operand_hold();
    int nread[ND] = '{2, 3, 1};
    for (int t = 0; t <= 11; t++) begin
      for (int i = 0; i < ND; i++) begin
        if (t >= 1 && t < 7 + nread[i]) begin
          total++;
          if (o_dp_op[i] !== 1'b1 || o_dp_const[i] !== 32'h40000000) begin
            bad++;
            $display("FAIL operand_hold dut%0d t=%0d dp_op=%b exp=1 dp_const=%h exp=40000000",
                     i, t, o_dp_op[i], o_dp_const[i]);
          end
        end
      end
      start = (t == 0);
      op_in = (t == 0) ? 1'b1 : ~op_in;
      constant_in = (t == 0) ? 32'h40000000 : ~constant_in;
      adv();
    end
    start = 1'b0;
  endtask

  task automatic test_ignored_start();
    int last_done = -100, reads0 = 0;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < ND; i++) begin
        int p, ph, n;
        n = nch(i); p = n + TOT + 2; ph = t % p;
        total++;
        if (o_rd_en[i] !== (ph >= 1 && ph <= n) || o_done[i] !== (ph == n + TOT + 1)) begin
          bad++;
          $display("FAIL held_start_schedule dut%0d t=%0d rd_en=%b done=%b exp rd_en=%b done=%b",
                   i, t, o_rd_en[i], o_done[i], (ph >= 1 && ph <= n), (ph == n + TOT + 1));
        end
      end
      if (o_rd_en[0] === 1'b1) begin
        reads0++;
        if (last_done >= 0) begin
          total++;
          if (t != last_done + 2) begin
            bad++; $display("FAIL restart_gap t=%0d first rd_en after done@%0d exp t=%0d", t, last_done, last_done + 2);
          end
          last_done = -100;
        end
      end
      if (o_done[0] === 1'b1) last_done = t;
      start = 1'b1; op_in = 1'b0; constant_in = 32'h1;
      adv();
    end
    total++;
    if (reads0 != 6) begin
      bad++; $display("FAIL held_start_read_count got=%0d exp=6", reads0);
    end
    start = 1'b0;
    repeat (15) adv();
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t <= 14; t++) begin
      if (t == 7) begin
        total++;
        if (o_wr_en[0] !== 1'b1) begin
          bad++; $display("FAIL mid_reset_first_write t=7 wr_en=%b exp=1", o_wr_en[0]);
        end
      end
      if (t >= 8) begin
        for (int i = 0; i < ND; i++) begin
          total++;
          if ({o_busy[i], o_done[i], o_rd_en[i], o_rd_addr[i], o_dp_op[i], o_dp_const[i],
               o_wr_en[i], o_wr_addr[i], o_wr_mask[i]} !== '0) begin
            bad++;
            $display("FAIL mid_reset_quiet dut%0d t=%0d busy=%b done=%b rd_en=%b dp_op=%b dp_const=%h wr_en=%b mask=%h (all expected 0)",
                     i, t, o_busy[i], o_done[i], o_rd_en[i], o_dp_op[i], o_dp_const[i], o_wr_en[i], o_wr_mask[i]);
          end
        end
      end
      start = (t == 0); op_in = 1'b1; constant_in = 32'h12345678;
      reset = (t == 7);
      adv();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < ND; i++) begin
        exp_t e;
        e = m_exp(i);
        total++;
        if (o_rd_en[i] !== e.rd_en || o_wr_en[i] !== e.wr_en || o_busy[i] !== e.busy || o_done[i] !== e.done) begin
          bad++;
          $display("FAIL rand_strobes dut%0d cyc=%0d rd=%b/%b wr=%b/%b busy=%b/%b done=%b/%b (got/exp)",
                   i, cyc, o_rd_en[i], e.rd_en, o_wr_en[i], e.wr_en, o_busy[i], e.busy, o_done[i], e.done);
        end
        total++;
        if (o_dp_op[i] !== m_op[i] || o_dp_const[i] !== m_cst[i]) begin
          bad++;
          $display("FAIL rand_operands dut%0d cyc=%0d op=%b exp=%b const=%h exp=%h",
                   i, cyc, o_dp_op[i], m_op[i], o_dp_const[i], m_cst[i]);
        end
        if (e.rd_en) begin
          total++;
          if (o_rd_addr[i] !== e.rd_addr) begin
            bad++; $display("FAIL rand_rd_addr dut%0d cyc=%0d got=%0d exp=%0d", i, cyc, o_rd_addr[i], e.rd_addr);
          end
        end
        if (e.wr_en) begin
          total++;
          if (o_wr_addr[i] !== e.wr_addr || o_wr_mask[i] !== e.mask) begin
            bad++;
            $display("FAIL rand_write dut%0d cyc=%0d addr=%0d exp=%0d mask=%h exp=%h",
                     i, cyc, o_wr_addr[i], e.wr_addr, o_wr_mask[i], e.mask);
          end
        end
      end
      start       = ($urandom_range(3) == 0);
      op_in       = 1'($urandom_range(1));
      constant_in = $urandom;
      reset       = ($urandom_range(79) == 0);
      adv();
    end
    reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_in = 1'b0; constant_in = '0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_operand_hold();
    test_ignored_start();
    test_reset_mid();
    repeat (2) adv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
